bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50000000: clk cycles per count step; legal range 2 to 2^26.
REQ-002 The block SHALL have input `clk`, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input `reset`, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input `load`, 1 bit: capture `load_val` as both the count and the reload value.
REQ-005 The block SHALL have input `load_val`, 12 bits: three BCD digits; [3:0] ones, [7:4] tens, [11:8] hundreds.
REQ-006 The block SHALL have input `start`, 1 bit: begin counting, or resume after pause.
REQ-007 The block SHALL have input `pause`, 1 bit: freeze counting.
REQ-008 The block SHALL have outputs `dig0`, `dig1` and `dig2`, 4 bits each: registered BCD ones, tens and hundreds; these feed the display digit multiplexer.
REQ-009 The block SHALL have output `running`, 1 bit: high while in RUN.
REQ-010 The block SHALL have output `done`, 1 bit: high while in DONE.
REQ-011 The block SHALL have output `expired`, 1 bit: one-cycle pulse when the count reaches 000.

Function
REQ-012 The block SHALL use states IDLE, RUN, PAUSED and DONE, and `load` SHALL have priority over `start` and `pause` in every state.
REQ-013 On `load`, each digit of `load_val` SHALL be clamped (values >9 become 9) and taken as count and reload value on the next edge; the state SHALL become IDLE and the prescaler SHALL clear.
REQ-014 On IDLE with `start` and count ≠ 000, the state SHALL go to RUN with the prescaler cleared; with count = 000 it SHALL go to DONE without an `expired` pulse.
REQ-015 On RUN with `pause`, the state SHALL go to PAUSED with the prescaler held; `start` and `pause` asserted together in RUN SHALL give PAUSED.
REQ-016 On PAUSED with `start` and not `pause`, the state SHALL go to RUN with the prescaler resumed from its held value.
REQ-017 In RUN, the prescaler SHALL count 0..PRESCALE-1; on the edge where it equals PRESCALE-1 it SHALL wrap to 0 and the count SHALL decrement by one in BCD.
REQ-018 The BCD decrement SHALL borrow ones 0→9 from tens, and tens 0→9 from hundreds (e.g. 100→099, 010→009).
REQ-019 A decrement from 001 SHALL give count 000, state DONE and `expired`=1, all registered on the same edge; `expired` SHALL be high for exactly one cycle.
REQ-020 DONE SHALL hold the count at 000; `start` and `pause` SHALL be ignored there, and only `load` or `reset` exits DONE.
REQ-021 In IDLE, PAUSED and DONE the count SHALL not change except by `load`.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-023 On `reset`, the block SHALL set `dig0`/`dig1`/`dig2`=0, reload value=000, prescaler=0, state IDLE, and `running`=`done`=`expired`=0.
REQ-024 `reset` SHALL override `load`, `start` and `pause` in the same cycle, and SHALL abort RUN or PAUSED immediately with no `expired` pulse.

Configuration
REQ-025 The block SHALL support macro TIMER_AUTORELOAD_EN to select auto-reload.
REQ-026 With TIMER_AUTORELOAD_EN defined, the decrement from 001 SHALL instead load the reload value, pulse `expired` and stay in RUN; if the reload value is 000 the block SHALL behave as when the macro is undefined.
REQ-027 With TIMER_AUTORELOAD_EN undefined, the block SHALL behave per REQ-019/REQ-020.

Verification (PRESCALE=4)
REQ-028 Reset test: assert `reset` for 2 cycles mid-RUN -> digits 0/0/0, `running`=0, `done`=0, `expired` never high.
REQ-029 Count-down test: load 0x123, then `start` -> 122 after 4 cycles; 000 with one `expired` pulse and `done`=1 after 492 cycles; count held thereafter.
REQ-030 Borrow test: load 0x100, then run one step -> 099; load 0x010, then run one step -> 009.
REQ-031 Pause test: pause after 2 prescaler cycles, hold 10 cycles, then `start` -> decrement occurs 2 cycles after resume; `start`+`pause` together in RUN -> PAUSED.
REQ-032 Clamp and edge test: load 0xFAF -> 9/9/9; load 0x000, then `start` -> DONE next cycle, no `expired`; `start` while in DONE -> no change.
REQ-033 Auto-reload test (macro defined): load 0x002, then `start` -> 001 after 4 cycles, 002 with an `expired` pulse after 8 cycles, `running` stays 1.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - three-digit BCD countdown timer with prescaler and pause/resume.
// Optional auto-reload on expiry is enabled by defining TIMER_AUTORELOAD_EN.
module bcd_countdown_timer #(
    parameter int PRESCALE = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic        running,
    output logic        done,
    output logic        expired
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   cnt_q, cnt_d;
    logic          expired_q, expired_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
`ifdef TIMER_AUTORELOAD_EN
    logic [11:0]   reload_q, reload_d;
`endif

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] h, t, o;
        {h, t, o} = v;
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else begin
            o = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd9;
                h = h - 4'd1;
            end
        end
        return {h, t, o};
    endfunction

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        reload_d  = reload_q;
`endif
        if (load) begin
            cnt_d   = {clamp9(load_val[11:8]), clamp9(load_val[7:4]), clamp9(load_val[3:0])};
`ifdef TIMER_AUTORELOAD_EN
            reload_d = {clamp9(load_val[11:8]), clamp9(load_val[7:4]), clamp9(load_val[3:0])};
`endif
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        presc_d = '0;
                        state_d = (cnt_q != 12'h000) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (presc_q == PMAX) begin
                        presc_d = '0;
                        if (cnt_q == 12'h001) begin
                            expired_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                            if (reload_q != 12'h000) begin
                                cnt_d = reload_q;
                            end else begin
                                cnt_d   = 12'h000;
                                state_d = DONE;
                            end
`else
                            cnt_d   = 12'h000;
                            state_d = DONE;
`endif
                        end else begin
                            cnt_d = bcd_dec(cnt_q);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            cnt_q     <= 12'h000;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            reload_q  <= 12'h000;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef TIMER_AUTORELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign dig0    = cnt_q[3:0];
    assign dig1    = cnt_q[7:4];
    assign dig2    = cnt_q[11:8];
    assign running = running_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for bcd_countdown_timer at PRESCALE=4.
module tb_bcd_countdown_timer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [11:0] load_val;
    logic        start;
    logic        pause;
    logic [3:0]  dig0, dig1, dig2;
    logic        running, done, expired;

    bcd_countdown_timer #(.PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .dig0(dig0), .dig1(dig1), .dig2(dig2),
        .running(running), .done(done), .expired(expired)
    );

    typedef struct {
        int          cyc;
        logic [11:0] digs;
        logic        run;
        logic        dn;
        logic        ex;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   stim_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && (sb[0].cyc <= cyc || stim_done)) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: check due at cycle %0d, monitor at cycle %0d", e.name, e.cyc, cyc);
            end else if ({dig2, dig1, dig0} !== e.digs || running !== e.run ||
                         done !== e.dn || expired !== e.ex) begin
                $display("FAIL %s @%0d: got digs=%h run=%b done=%b exp=%b, want digs=%h run=%b done=%b exp=%b",
                         e.name, cyc, {dig2, dig1, dig0}, running, done, expired,
                         e.digs, e.run, e.dn, e.ex);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int k, input logic [11:0] d, input logic r,
                             input logic dn, input logic ex, input string nm);
        exp_t e;
        e = '{cyc + k, d, r, dn, ex, nm};
        sb.push_back(e);
    endtask

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_val = v;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = 12'h000; start = 1'b0; pause = 1'b0;
        step(2);
        reset = 1'b0;
        expect_at(0, 12'h000, 0, 0, 0, "reset_state");

        // Count-down from 123: one step every 4 cycles, expiry at cycle 492.
        do_load(12'h123);
        do_start();
        for (int k = 0; k <= 495; k++) begin
            int n;
`ifdef TIMER_AUTORELOAD_EN
            n = (k < 492) ? 123 - k / 4 : 123 - (k - 492) / 4;
            expect_at(k, to_bcd(n), 1, 0, (k == 492), "countdown");
`else
            n = (k < 492) ? 123 - k / 4 : 0;
            expect_at(k, to_bcd(n), (k < 492), (k >= 492), (k == 492), "countdown");
`endif
        end
        step(496);
`ifndef TIMER_AUTORELOAD_EN
        step(20);
        expect_at(0, 12'h000, 0, 1, 0, "done_hold");
`endif

        // Reset mid-RUN aborts with no expiry.
        do_load(12'h050);
        do_start();
        step(5);
        expect_at(0, 12'h049, 1, 0, 0, "pre_reset_run");
        reset = 1'b1;
        expect_at(1, 12'h000, 0, 0, 0, "reset_midrun");
        expect_at(2, 12'h000, 0, 0, 0, "reset_midrun");
        step(2);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) expect_at(k, 12'h000, 0, 0, 0, "post_reset");
        step(8);

        // Borrow across digits.
        do_load(12'h100);
        do_start();
        expect_at(0, 12'h100, 1, 0, 0, "borrow100_start");
        expect_at(3, 12'h100, 1, 0, 0, "borrow100_pre");
        expect_at(4, 12'h099, 1, 0, 0, "borrow100");
        step(4);
        expect_at(1, 12'h010, 0, 0, 0, "load010");
        do_load(12'h010);
        do_start();
        expect_at(4, 12'h009, 1, 0, 0, "borrow010");
        step(4);

        // Pause holds prescaler phase; resume decrements 2 cycles later.
        do_load(12'h005);
        do_start();
        step(2);
        pause = 1'b1;
        for (int k = 1; k <= 10; k++) expect_at(k, 12'h005, 0, 0, 0, "paused_hold");
        step(10);
        pause = 1'b0; start = 1'b1;
        expect_at(1, 12'h005, 1, 0, 0, "resume");
        expect_at(2, 12'h005, 1, 0, 0, "resume_pre");
        expect_at(3, 12'h004, 1, 0, 0, "resume_dec");
        step(1);
        start = 1'b0;
        step(2);
        start = 1'b1; pause = 1'b1;
        expect_at(1, 12'h004, 0, 0, 0, "start_pause_run");
        expect_at(2, 12'h004, 0, 0, 0, "start_pause_held");
        step(2);
        start = 1'b0; pause = 1'b0;
        expect_at(1, 12'h004, 0, 0, 0, "paused_idle_inputs");
        step(1);

        // Clamp, zero start, DONE ignores start/pause.
        expect_at(1, 12'h999, 0, 0, 0, "clamp_FAF");
        do_load(12'hFAF);
        for (int k = 1; k <= 3; k++) expect_at(k, 12'h999, 0, 0, 0, "idle_hold");
        step(3);
        expect_at(1, 12'h000, 0, 0, 0, "load000");
        do_load(12'h000);
        expect_at(1, 12'h000, 0, 1, 0, "zero_start_done");
        do_start();
        start = 1'b1; pause = 1'b1;
        expect_at(1, 12'h000, 0, 1, 0, "done_ignores");
        expect_at(2, 12'h000, 0, 1, 0, "done_ignores");
        step(2);

        // Load wins over start/pause; reset wins over everything.
        load = 1'b1; load_val = 12'h007;
        expect_at(1, 12'h007, 0, 0, 0, "load_priority");
        step(1);
        load = 1'b0; start = 1'b0; pause = 1'b0;
        expect_at(1, 12'h007, 0, 0, 0, "load_priority_idle");
        step(1);
        reset = 1'b1; load = 1'b1; load_val = 12'h345; start = 1'b1;
        expect_at(1, 12'h000, 0, 0, 0, "reset_override");
        step(1);
        reset = 1'b0; load = 1'b0; start = 1'b0;
        expect_at(1, 12'h000, 0, 0, 0, "reset_override_idle");
        step(1);

        // Expiry from 002: auto-reload keeps running, otherwise DONE.
        do_load(12'h002);
        do_start();
        expect_at(3, 12'h002, 1, 0, 0, "ar_pre");
        expect_at(4, 12'h001, 1, 0, 0, "ar_first");
        expect_at(7, 12'h001, 1, 0, 0, "ar_mid");
`ifdef TIMER_AUTORELOAD_EN
        expect_at(8, 12'h002, 1, 0, 1, "ar_reload");
        expect_at(9, 12'h002, 1, 0, 0, "ar_after");
`else
        expect_at(8, 12'h000, 0, 1, 1, "expire_002");
        expect_at(9, 12'h000, 0, 1, 0, "expire_002_after");
`endif
        step(9);

        step(3);
        stim_done = 1'b1;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
